fir_packet_sequencer: RTL and testbench
=======================================

Name: fir_packet_sequencer

Overview:
- Packet sequencer between the SPI slave and the FIR core; successor to the fixed 16-bit, 8-sample, single-channel packet glue.
- Generalised in sample widths, samples per packet and channel count; channels in one packet are filtered one after another by a single shared FIR core.
- Adds overrun detection and an accumulator-to-output width reduction stage.
- Output packets return to the SPI master delayed by two packet transactions.

Parameters:
- SAMPLES_NUM, 8, samples per channel per packet (1..16).
- CHANNELS, 2, channels interleaved in one packet (1..4).
- IN_WIDTH, 16, input sample width.
- OUT_WIDTH, 32, returned sample width.
- ACC_WIDTH, 40, FIR core result width per sample (must be >= OUT_WIDTH).
- Derived: PACKET_BITS = CHANNELS*SAMPLES_NUM*OUT_WIDTH.

Ports:
- clkIn  in  1  system clock.
- nResetIn  in  1  reset; synchronous, active-low.
- rxValidIn  in  1  one-cycle pulse: full packet received from SPI slave.
- rxDataIn  in  PACKET_BITS  received packet, msb-first.
- txDataOut  out  PACKET_BITS  packet the SPI slave shifts out during the next transaction.
- firStartOut  out  1  one-cycle start pulse to the FIR core.
- firChannelOut  out  $clog2(CHANNELS) (min 1)  channel index; selects the coefficient bank.
- firDataOut  out  IN_WIDTH*SAMPLES_NUM  samples for the current channel; sample 0 in the MSBs.
- firDoneIn  in  1  one-cycle pulse from the FIR core: result valid.
- firDataIn  in  ACC_WIDTH*SAMPLES_NUM  FIR core results; sample 0 in the MSBs.
- clearIn  in  1  clears sticky flags.
- busyOut  out  1  high while state != IDLE.
- overrunOut  out  1  sticky: packet arrived while busy.
- satOut  out  1  sticky: a saturation occurred (feature only; 0 otherwise).

Behaviour:
- Reset (nResetIn=0 at a clkIn edge; applies mid-operation too):
  - state goes to IDLE; all outputs, the input buffer, the result buffer and the channel counter are 0.
  - An in-flight core firDoneIn after reset is ignored.
- Input layout: channel c, sample s occupies rxDataIn[PACKET_BITS-1-(c*SAMPLES_NUM+s)*IN_WIDTH -: IN_WIDTH]. Remaining low bits are don't-care.
- Output layout: channel c, sample s occupies txDataOut[PACKET_BITS-1-(c*SAMPLES_NUM+s)*OUT_WIDTH -: OUT_WIDTH].
- FSM states: IDLE, START, WAIT.
  - IDLE + rxValidIn: latch rxDataIn; chan=0; txDataOut<=resultBuf; go to START.
  - START: firStartOut=1 for exactly one cycle; firChannelOut=chan; firDataOut=slice(chan) (held stable until the next START); go to WAIT.
  - WAIT + firDoneIn: reduce each sample (see Arithmetic) into resultBuf slot chan.
    - If chan==CHANNELS-1, go to IDLE.
    - Otherwise chan++ and go to START.
- Latency: txDataOut during transaction N+1 carries the results of packet N-1.
- Arithmetic (default build): reduction is truncation to the low OUT_WIDTH bits of the signed ACC_WIDTH value.
- Overrun: rxValidIn while in START or WAIT.
  - The packet is dropped (input buffer unchanged).
  - txDataOut <= all zeros; overrunOut <= 1.
  - Sequencing of the current packet continues.
- Simultaneous firDoneIn on the last channel and rxValidIn:
  - Not an overrun; the packet is accepted.
  - txDataOut receives the resultBuf content including the just-reduced last channel (bypass).
  - The FSM goes directly to START with chan=0.
- clearIn clears overrunOut and satOut next cycle. If a set condition occurs in the same cycle, set wins.
- firDoneIn in IDLE or START is ignored.

Optional Feature:
- Macro: FIR_PACKET_SATURATE_EN.
- Defined: each signed ACC_WIDTH result outside the OUT_WIDTH signed range is clamped.
  - Clamp to +(2^(OUT_WIDTH-1)-1) or -2^(OUT_WIDTH-1).
  - Any clamp sets sticky satOut.
- Undefined: plain truncation; satOut tied to 0.

Decomposition:
- Package fir_packet_pkg:
  - state enum {IDLE, START, WAIT};
  - functions for slice offsets and PACKET_BITS;
  - width-check constants.
- Sub-module fir_packet_reduce: one sample, ACC_WIDTH->OUT_WIDTH, saturate/truncate plus a clamp flag. Instantiated SAMPLES_NUM times via generate.

Test Plan:
- Reset mid-WAIT (CHANNELS=2) -> next cycle busyOut=0, txDataOut=0, firStartOut=0. A later firDoneIn is ignored.
- Packet ch0 samples 0x0001..0x0008, ch1 0x0101..0x0108; model core returns result = sample*2 -> firStartOut pulses twice, firChannelOut 0 then 1. The third rxValidIn shows txDataOut ch0 s0=0x00000002, ch1 s7=0x00000210.
- rxValidIn in WAIT -> overrunOut=1, txDataOut=0, the second firStartOut still carries the old ch1 data. clearIn then drops overrunOut to 0.
- firDoneIn (last channel) and rxValidIn in the same cycle -> overrunOut stays 0; txDataOut includes the last-channel result; firStartOut fires the next cycle with chan=0.
- FIR_PACKET_SATURATE_EN, core result 0x00_8000_0000 -> sample 0x7FFFFFFF, satOut=1. Without the macro -> 0x80000000, satOut=0.
- SAMPLES_NUM=1, CHANNELS=1 -> one start per packet; two-packet latency holds.

Source files
------------

// File: rtl/fir_packet_pkg.sv
// Shared types and sizing helpers for the FIR packet sequencer.
package fir_packet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } fir_state_e;

    localparam int MAX_SAMPLES  = 16;
    localparam int MAX_CHANNELS = 4;

    function automatic int packetBits(input int channels, input int samples, input int outWidth);
        return channels * samples * outWidth;
    endfunction

    function automatic int chanWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Msb index of element idx in a vector packed msb-first with elements of the given width.
    function automatic int sliceMsb(input int totalBits, input int idx, input int width);
        return totalBits - 1 - idx * width;
    endfunction

    function automatic bit paramsOk(input int samples, input int channels,
                                    input int inWidth, input int outWidth, input int accWidth);
        return (samples >= 1) && (samples <= MAX_SAMPLES) &&
               (channels >= 1) && (channels <= MAX_CHANNELS) &&
               (inWidth >= 1) && (inWidth <= outWidth) && (accWidth >= outWidth);
    endfunction

endpackage

// File: rtl/fir_packet_sequencer_if.sv
// Packet and FIR-core handshake bundle; master is the sequencer, slave is the SPI/FIR side.
interface fir_packet_sequencer_if
#(
    parameter int SAMPLES_NUM = 8,
    parameter int CHANNELS    = 2,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40
);
    import fir_packet_pkg::*;

    localparam int PACKET_BITS = packetBits(CHANNELS, SAMPLES_NUM, OUT_WIDTH);
    localparam int CHAN_WIDTH  = chanWidth(CHANNELS);

    logic                            rxValidIn;
    logic [PACKET_BITS-1:0]          rxDataIn;
    logic [PACKET_BITS-1:0]          txDataOut;
    logic                            firStartOut;
    logic [CHAN_WIDTH-1:0]           firChannelOut;
    logic [IN_WIDTH*SAMPLES_NUM-1:0] firDataOut;
    logic                            firDoneIn;
    logic [ACC_WIDTH*SAMPLES_NUM-1:0] firDataIn;
    logic                            clearIn;
    logic                            busyOut;
    logic                            overrunOut;
    logic                            satOut;

    modport master (
        input  rxValidIn, rxDataIn, firDoneIn, firDataIn, clearIn,
        output txDataOut, firStartOut, firChannelOut, firDataOut, busyOut, overrunOut, satOut
    );

    modport slave (
        output rxValidIn, rxDataIn, firDoneIn, firDataIn, clearIn,
        input  txDataOut, firStartOut, firChannelOut, firDataOut, busyOut, overrunOut, satOut
    );

endinterface

// File: rtl/fir_packet_reduce.sv
// One-sample ACC_WIDTH -> OUT_WIDTH reduction; clamps to the signed output range when
// FIR_PACKET_SATURATE_EN is defined, otherwise truncates and never flags a clamp.
module fir_packet_reduce
#(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 32
)
(
    input  logic [ACC_WIDTH-1:0] accIn,
    output logic [OUT_WIDTH-1:0] sampleOut,
    output logic                 clampOut
);

`ifdef FIR_PACKET_SATURATE_EN
    // Value fits when the output sign bit and every discarded bit agree.
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    logic                         fits;

    assign upper     = accIn[ACC_WIDTH-1:OUT_WIDTH-1];
    assign fits      = (&upper) | ~(|upper);
    assign clampOut  = ~fits;
    assign sampleOut = fits            ? accIn[OUT_WIDTH-1:0] :
                       accIn[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                            {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    logic unusedAccHigh;

    assign unusedAccHigh = ^accIn;
    assign sampleOut     = accIn[OUT_WIDTH-1:0];
    assign clampOut      = 1'b0;
`endif

endmodule

// File: rtl/fir_packet_sequencer.sv
// Sequences SPI packets through a shared FIR core channel by channel; results return two
// transactions later. Optional clamping: FIR_PACKET_SATURATE_EN.
//
// state | meaning
// IDLE  | waiting for a packet
// START | one-cycle start pulse for channel chan
// WAIT  | waiting for the core result of channel chan
module fir_packet_sequencer
    import fir_packet_pkg::*;
#(
    parameter int SAMPLES_NUM = 8,
    parameter int CHANNELS    = 2,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40
)
(
    input  logic                    clkIn,
    input  logic                    nResetIn,
    fir_packet_sequencer_if.master  bus
);

    localparam int PACKET_BITS = packetBits(CHANNELS, SAMPLES_NUM, OUT_WIDTH);
    localparam int CHAN_WIDTH  = chanWidth(CHANNELS);
    localparam int CHAN_SLOTS  = 1 << CHAN_WIDTH;
    localparam int IN_SLICE    = IN_WIDTH * SAMPLES_NUM;
    localparam int OUT_SLICE   = OUT_WIDTH * SAMPLES_NUM;
    localparam int ACC_SLICE   = ACC_WIDTH * SAMPLES_NUM;
    localparam int IN_TOTAL    = CHANNELS * IN_SLICE;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_WAIT  = WAIT;

    localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(CHANNELS - 1);

    if (!paramsOk(SAMPLES_NUM, CHANNELS, IN_WIDTH, OUT_WIDTH, ACC_WIDTH)) begin : g_badParams
        $error("fir_packet_sequencer: unsupported parameter combination");
    end

    logic [1:0]             state;
    logic [CHAN_WIDTH-1:0]  chan;
    logic [IN_TOTAL-1:0]    inBuf;
    logic [PACKET_BITS-1:0] resultBuf;
    logic [PACKET_BITS-1:0] resultNext;
    logic [PACKET_BITS-1:0] txData;
    logic [OUT_SLICE-1:0]   reduced;
    logic [SAMPLES_NUM-1:0] clampVec;
    logic [IN_SLICE-1:0]    inSlices [CHAN_SLOTS];
    logic                   overrun;
    logic                   sat;
    logic                   doneHit;
    logic                   lastDone;
    logic                   acceptPkt;
    logic                   overrunHit;
    logic                   unusedRxTail;

    for (genvar s = 0; s < SAMPLES_NUM; s++) begin : g_reduce
        fir_packet_reduce #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_reduce (
            .accIn     (bus.firDataIn[sliceMsb(ACC_SLICE, s, ACC_WIDTH) -: ACC_WIDTH]),
            .sampleOut (reduced[sliceMsb(OUT_SLICE, s, OUT_WIDTH) -: OUT_WIDTH]),
            .clampOut  (clampVec[s])
        );
    end

    assign doneHit    = (state == S_WAIT) && bus.firDoneIn;
    assign lastDone   = doneHit && (chan == LAST_CHAN);
    assign acceptPkt  = bus.rxValidIn && ((state == S_IDLE) || lastDone);
    assign overrunHit = bus.rxValidIn && !acceptPkt;

    // resultNext already holds the channel being finished, so a packet accepted on the
    // last done returns the complete result set.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
        assign resultNext[sliceMsb(PACKET_BITS, c, OUT_SLICE) -: OUT_SLICE] =
            (doneHit && (chan == CHAN_WIDTH'(c))) ? reduced
                                                  : resultBuf[sliceMsb(PACKET_BITS, c, OUT_SLICE) -: OUT_SLICE];
    end

    for (genvar c = 0; c < CHAN_SLOTS; c++) begin : g_inSlice
        if (c < CHANNELS) begin : g_used
            assign inSlices[c] = inBuf[sliceMsb(IN_TOTAL, c, IN_SLICE) -: IN_SLICE];
        end else begin : g_pad
            assign inSlices[c] = '0;
        end
    end

    assign unusedRxTail = ^bus.rxDataIn;

    always_ff @(posedge clkIn) begin
        if (!nResetIn) begin
            state     <= S_IDLE;
            chan      <= '0;
            inBuf     <= '0;
            resultBuf <= '0;
            txData    <= '0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            resultBuf <= resultNext;

            if (acceptPkt) begin
                inBuf  <= bus.rxDataIn[PACKET_BITS-1 -: IN_TOTAL];
                txData <= resultNext;
            end else if (overrunHit) begin
                txData <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.rxValidIn) begin
                        chan  <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.firDoneIn) begin
                        if (chan == LAST_CHAN) begin
                            chan  <= '0;
                            state <= bus.rxValidIn ? S_START : S_IDLE;
                        end else begin
                            chan  <= chan + CHAN_WIDTH'(1);
                            state <= S_START;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (overrunHit) begin
                overrun <= 1'b1;
            end else if (bus.clearIn) begin
                overrun <= 1'b0;
            end

            if (doneHit && (|clampVec)) begin
                sat <= 1'b1;
            end else if (bus.clearIn) begin
                sat <= 1'b0;
            end
        end
    end

    assign bus.txDataOut     = txData;
    assign bus.firStartOut   = (state == S_START);
    assign bus.firChannelOut = chan;
    assign bus.firDataOut    = inSlices[chan];
    assign bus.busyOut       = (state != S_IDLE);
    assign bus.overrunOut    = overrun;
    assign bus.satOut        = sat;

endmodule

// File: tb/tb_fir_packet_sequencer.sv
// Directed bench for fir_packet_sequencer: a 2-channel x 8-sample instance and a 1x1 instance.
module tb_fir_packet_sequencer;
    import fir_packet_pkg::*;

`ifdef FIR_PACKET_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nReset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fir_packet_sequencer_if #(.SAMPLES_NUM(8), .CHANNELS(2), .IN_WIDTH(16),
                              .OUT_WIDTH(32), .ACC_WIDTH(40)) bus ();
    fir_packet_sequencer_if #(.SAMPLES_NUM(1), .CHANNELS(1), .IN_WIDTH(16),
                              .OUT_WIDTH(32), .ACC_WIDTH(40)) bus1 ();

    fir_packet_sequencer #(.SAMPLES_NUM(8), .CHANNELS(2), .IN_WIDTH(16),
                           .OUT_WIDTH(32), .ACC_WIDTH(40)) dut (
        .clkIn    (clk),
        .nResetIn (nReset),
        .bus      (bus)
    );

    fir_packet_sequencer #(.SAMPLES_NUM(1), .CHANNELS(1), .IN_WIDTH(16),
                           .OUT_WIDTH(32), .ACC_WIDTH(40)) dut1 (
        .clkIn    (clk),
        .nResetIn (nReset),
        .bus      (bus1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel c sample s = base + c*0x100 + s + 1; low half of the packet left zero.
    function automatic logic [511:0] mkPkt(input logic [15:0] base);
        logic [511:0] p;
        p = '0;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 8; s++)
                p[511-(c*8+s)*16 -: 16] = base + 16'(c*256 + s + 1);
        return p;
    endfunction

    function automatic logic [127:0] slice(input logic [511:0] p, input int c);
        return p[511-c*128 -: 128];
    endfunction

    // Core model: every result is twice its input sample.
    function automatic logic [319:0] dbl(input logic [511:0] p, input int c);
        logic [319:0] r;
        r = '0;
        for (int s = 0; s < 8; s++)
            r[319-s*40 -: 40] = 40'(p[511-(c*8+s)*16 -: 16]) << 1;
        return r;
    endfunction

    function automatic logic [511:0] expTx(input logic [511:0] p);
        logic [511:0] e;
        e = '0;
        for (int k = 0; k < 16; k++)
            e[511-k*32 -: 32] = 32'(p[511-k*16 -: 16]) << 1;
        return e;
    endfunction

    task automatic sendPkt(input logic [511:0] p);
        bus.rxValidIn = 1'b1;
        bus.rxDataIn  = p;
        tick;
        bus.rxValidIn = 1'b0;
    endtask

    // Bounded wait for the start pulse, check it, then step into WAIT.
    task automatic awaitStart(input string tag, input int ch, input logic [127:0] data);
        int n;
        n = 0;
        while (bus.firStartOut !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_start"}, bus.firStartOut, 1);
        check({tag, "_chan"}, bus.firChannelOut, ch);
        check({tag, "_data"}, bus.firDataOut, data);
        tick;
    endtask

    task automatic coreDone(input logic [319:0] r);
        tick;
        bus.firDataIn = r;
        bus.firDoneIn = 1'b1;
        tick;
        bus.firDoneIn = 1'b0;
    endtask

    initial begin
        logic [511:0] pA, pB, pC, pE, pF, pG, t;
        logic [319:0] r;
        int n;

        nReset = 1'b0;
        bus.rxValidIn = 1'b0;  bus.rxDataIn = '0;  bus.firDoneIn = 1'b0;
        bus.firDataIn = '0;    bus.clearIn = 1'b0;
        bus1.rxValidIn = 1'b0; bus1.rxDataIn = '0; bus1.firDoneIn = 1'b0;
        bus1.firDataIn = '0;   bus1.clearIn = 1'b0;
        repeat (3) tick;

        check("rst_busy", bus.busyOut, 0);
        check("rst_tx", bus.txDataOut, 0);
        check("rst_start", bus.firStartOut, 0);
        check("rst_chan", bus.firChannelOut, 0);
        check("rst_firdata", bus.firDataOut, 0);
        check("rst_overrun", bus.overrunOut, 0);
        check("rst_sat", bus.satOut, 0);
        check("rst1_busy", bus1.busyOut, 0);
        nReset = 1'b1;
        tick;

        // Reset while waiting on the core; the late done must be ignored.
        pA = mkPkt(16'h0000);
        sendPkt(pA);
        awaitStart("rstw_c0", 0, slice(pA, 0));
        check("rstw_busy_wait", bus.busyOut, 1);
        nReset = 1'b0;
        tick;
        nReset = 1'b1;
        check("rstw_busy", bus.busyOut, 0);
        check("rstw_tx", bus.txDataOut, 0);
        check("rstw_start", bus.firStartOut, 0);
        check("rstw_firdata", bus.firDataOut, 0);
        bus.firDataIn = '1;
        bus.firDoneIn = 1'b1;
        tick;
        bus.firDoneIn = 1'b0;
        check("rstw_late_busy", bus.busyOut, 0);
        check("rstw_late_start", bus.firStartOut, 0);

        // Two-channel packets and two-transaction latency.
        sendPkt(pA);
        check("p1_tx", bus.txDataOut, 0);
        awaitStart("p1c0", 0, slice(pA, 0));
        coreDone(dbl(pA, 0));
        awaitStart("p1c1", 1, slice(pA, 1));
        coreDone(dbl(pA, 1));
        check("p1_idle", bus.busyOut, 0);
        check("p1_nostart", bus.firStartOut, 0);

        pB = mkPkt(16'h1000);
        sendPkt(pB);
        t = bus.txDataOut;
        check("p2_tx", t, expTx(pA));
        check("p2_tx_c0s0", t[511 -: 32], 32'h0000_0002);
        check("p2_tx_c1s7", t[31 + 32*16 - 16*32 -: 32], 32'h0000_0210);
        awaitStart("p2c0", 0, slice(pB, 0));
        coreDone(dbl(pB, 0));
        awaitStart("p2c1", 1, slice(pB, 1));
        coreDone(dbl(pB, 1));

        pC = mkPkt(16'h2000);
        sendPkt(pC);
        check("p3_tx", bus.txDataOut, expTx(pB));

        // Overrun during WAIT: packet dropped, current sequencing continues.
        awaitStart("ovr_c0", 0, slice(pC, 0));
        bus.rxValidIn = 1'b1;
        bus.rxDataIn  = mkPkt(16'h5000);
        tick;
        bus.rxValidIn = 1'b0;
        check("ovr_flag", bus.overrunOut, 1);
        check("ovr_tx", bus.txDataOut, 0);
        check("ovr_busy", bus.busyOut, 1);
        coreDone(dbl(pC, 0));
        awaitStart("ovr_c1", 1, slice(pC, 1));
        bus.clearIn = 1'b1;
        tick;
        bus.clearIn = 1'b0;
        check("ovr_clear", bus.overrunOut, 0);
        bus.clearIn   = 1'b1;
        bus.rxValidIn = 1'b1;
        tick;
        bus.clearIn   = 1'b0;
        bus.rxValidIn = 1'b0;
        check("ovr_set_wins", bus.overrunOut, 1);
        bus.clearIn = 1'b1;
        tick;
        bus.clearIn = 1'b0;
        check("ovr_clear2", bus.overrunOut, 0);
        coreDone(dbl(pC, 1));
        check("ovr_idle", bus.busyOut, 0);

        // Last-channel done together with a new packet: accepted with bypassed results.
        pE = mkPkt(16'h3000);
        sendPkt(pE);
        check("byp_prev_tx", bus.txDataOut, expTx(pC));
        awaitStart("byp_c0", 0, slice(pE, 0));
        coreDone(dbl(pE, 0));
        awaitStart("byp_c1", 1, slice(pE, 1));
        tick;
        pF = mkPkt(16'h4000);
        bus.firDataIn = dbl(pE, 1);
        bus.firDoneIn = 1'b1;
        bus.rxValidIn = 1'b1;
        bus.rxDataIn  = pF;
        tick;
        bus.firDoneIn = 1'b0;
        bus.rxValidIn = 1'b0;
        check("byp_overrun", bus.overrunOut, 0);
        check("byp_tx", bus.txDataOut, expTx(pE));
        check("byp_start", bus.firStartOut, 1);
        check("byp_chan", bus.firChannelOut, 0);
        check("byp_firdata", bus.firDataOut, slice(pF, 0));
        awaitStart("byp_f0", 0, slice(pF, 0));
        coreDone(dbl(pF, 0));
        awaitStart("byp_f1", 1, slice(pF, 1));
        coreDone(dbl(pF, 1));

        // Out-of-range core results: clamped with the feature, truncated without.
        pG = mkPkt(16'h6000);
        sendPkt(pG);
        check("sat_prev_tx", bus.txDataOut, expTx(pF));
        awaitStart("sat_c0", 0, slice(pG, 0));
        r = dbl(pG, 0);
        r[319 -: 40] = 40'h00_8000_0000;
        r[279 -: 40] = 40'hFF_FFFF_FFFE;
        r[239 -: 40] = 40'hFF_7FFF_FFFF;
        coreDone(r);
        check("sat_flag", bus.satOut, SAT_EN ? 1 : 0);
        awaitStart("sat_c1", 1, slice(pG, 1));
        coreDone(dbl(pG, 1));
        sendPkt(mkPkt(16'h7000));
        t = bus.txDataOut;
        check("sat_s0", t[511 -: 32], SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000);
        check("sat_s1", t[479 -: 32], 32'hFFFF_FFFE);
        check("sat_s2", t[447 -: 32], SAT_EN ? 32'h8000_0000 : 32'h7FFF_FFFF);
        check("sat_s3", t[415 -: 32], 32'h0000_C008);
        bus.clearIn = 1'b1;
        tick;
        bus.clearIn = 1'b0;
        check("sat_clear", bus.satOut, 0);

        // Single channel, single sample.
        bus1.rxValidIn = 1'b1;
        bus1.rxDataIn  = 32'h0005_0000;
        tick;
        bus1.rxValidIn = 1'b0;
        check("one_p1_tx", bus1.txDataOut, 0);
        check("one_p1_start", bus1.firStartOut, 1);
        check("one_p1_chan", bus1.firChannelOut, 0);
        check("one_p1_data", bus1.firDataOut, 16'h0005);
        repeat (2) tick;
        bus1.firDataIn = 40'h00_0000_000A;
        bus1.firDoneIn = 1'b1;
        tick;
        bus1.firDoneIn = 1'b0;
        check("one_p1_idle", bus1.busyOut, 0);
        check("one_p1_onestart", bus1.firStartOut, 0);

        bus1.rxValidIn = 1'b1;
        bus1.rxDataIn  = 32'h0007_1234;
        tick;
        bus1.rxValidIn = 1'b0;
        check("one_p2_tx", bus1.txDataOut, 32'h0000_000A);
        check("one_p2_data", bus1.firDataOut, 16'h0007);
        n = 0;
        while (bus1.busyOut === 1'b1 && bus1.firStartOut === 1'b1 && n < 20) begin
            tick;
            n++;
        end
        tick;
        bus1.firDataIn = 40'h00_0000_000E;
        bus1.firDoneIn = 1'b1;
        tick;
        bus1.firDoneIn = 1'b0;
        check("one_p2_idle", bus1.busyOut, 0);

        bus1.rxValidIn = 1'b1;
        bus1.rxDataIn  = 32'h0001_0000;
        tick;
        bus1.rxValidIn = 1'b0;
        check("one_p3_tx", bus1.txDataOut, 32'h0000_000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
